// File: rtl/bist_response_analyzer_if.sv
// Bundle between a memory BIST read engine and the response analyzer.
//
// Handshake: rd_valid qualifies rd_addr/rd_data. There is no ready; the
// analyzer takes exactly one word on every rising clk edge where it is in
// RUN and rd_valid=1. Words presented in IDLE or DONE are dropped, and so is
// a word presented in the same cycle as start. start is a single-cycle pulse.
// seed_value, invert and num_words are sampled only on that cycle.
interface bist_response_analyzer_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int ERR_WIDTH  = 16
) ();
  logic                  start;
  logic [WIDTH-1:0]      seed_value;
  logic                  invert;
  logic [ADDR_WIDTH:0]   num_words;
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0]      rd_data;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ERR_WIDTH-1:0]  err_count;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic [WIDTH-1:0]      fail_data;
  logic [WIDTH-1:0]      fail_exp;
  logic [WIDTH-1:0]      signature;

  // Read engine / controller side
  modport master (
    output start, seed_value, invert, num_words, rd_valid, rd_addr, rd_data,
    input  busy, done, pass, err_count, fail_addr, fail_data, fail_exp, signature
  );

  // Analyzer side
  modport slave (
    input  start, seed_value, invert, num_words, rd_valid, rd_addr, rd_data,
    output busy, done, pass, err_count, fail_addr, fail_data, fail_exp, signature
  );
endinterface

// File: rtl/bist_response_analyzer.sv
// Memory BIST response analyzer. It regenerates the expected data pattern
// with a 32-bit LFSR and compares every accepted read word against it. It
// keeps a saturating mismatch count, records the first failing word, and
// compacts all accepted words into a MISR signature. The LFSR and MISR
// feedback taps (31, 21, 1, 0) only make sense for WIDTH=32.
module bist_response_analyzer #(
  parameter int          WIDTH      = 32,
  parameter logic [31:0] SEED       = 32'hACE1_CAFE,
  parameter int          ADDR_WIDTH = 10,
  parameter int          ERR_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bist_response_analyzer_if.slave bus,
  output logic [1:0]              o_dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [WIDTH-1:0]      r_exp;
  logic                  r_invert;
  logic [ADDR_WIDTH:0]   r_num_words;
  logic [ADDR_WIDTH:0]   r_word_cnt;
  logic [ERR_WIDTH-1:0]  r_err_count;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [WIDTH-1:0]      r_fail_data;
  logic [WIDTH-1:0]      r_fail_exp;
  logic [WIDTH-1:0]      r_sig;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;

  logic [WIDTH-1:0]      w_cmp;
  logic                  w_mismatch;
  logic                  w_accept;
  logic                  w_last;
  logic [WIDTH-1:0]      w_exp_next;
  logic [WIDTH-1:0]      w_sig_next;

  // Compare value, next LFSR/MISR states and the word-accept qualifier
  always_comb begin
    w_cmp      = r_invert ? ~r_exp : r_exp;
    w_mismatch = (bus.rd_data != w_cmp);
    w_accept   = (r_state == S_RUN) && bus.rd_valid && !bus.start;
    w_last     = (r_word_cnt == (r_num_words - 1'b1));
    w_exp_next = {r_exp[WIDTH-2:0], r_exp[31] ^ r_exp[21] ^ r_exp[1] ^ r_exp[0]};
    w_sig_next = {r_sig[WIDTH-2:0], r_sig[31] ^ r_sig[21] ^ r_sig[1] ^ r_sig[0]}
                 ^ bus.rd_data;
  end

  // FSM, pattern generator, error capture and signature compaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_exp       <= SEED[WIDTH-1:0];
      r_invert    <= 1'b0;
      r_num_words <= '0;
      r_word_cnt  <= '0;
      r_err_count <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
      r_fail_exp  <= '0;
      r_sig       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else if (bus.start) begin
      // start wins in every state, including an abort of a run in flight
      r_exp       <= bus.seed_value;
      r_invert    <= bus.invert;
      r_num_words <= bus.num_words;
      r_word_cnt  <= '0;
      r_err_count <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
      r_fail_exp  <= '0;
      r_sig       <= '0;
      if (bus.num_words == '0) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_pass  <= 1'b1;
      end else begin
        r_state <= S_RUN;
        r_busy  <= 1'b1;
        r_done  <= 1'b0;
        r_pass  <= 1'b0;
      end
    end else if (w_accept) begin
      r_exp      <= w_exp_next;
      r_sig      <= w_sig_next;
      r_word_cnt <= r_word_cnt + 1'b1;
      if (w_mismatch) begin
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + 1'b1;
        end
        // A zero count means no mismatch yet, because saturation never wraps
        if (r_err_count == '0) begin
          r_fail_addr <= bus.rd_addr;
          r_fail_data <= bus.rd_data;
          r_fail_exp  <= w_cmp;
        end
      end
      if (w_last) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_pass  <= (r_err_count == '0) && !w_mismatch;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err_count;
  assign bus.fail_addr = r_fail_addr;
  assign bus.fail_data = r_fail_data;
  assign bus.fail_exp  = r_fail_exp;
  assign bus.signature = r_sig;
  assign o_dbg_state   = r_state;

endmodule
